// File: rtl/y86_pkg.sv
// Shared constants, state encoding and helpers for the Y86 SEQ stage sequencer.
package y86_pkg;

  // Architectural status codes
  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [1:0] STAT_HLT = 2'd1;
  localparam logic [1:0] STAT_ADR = 2'd2;
  localparam logic [1:0] STAT_INS = 2'd3;

  // Instruction codes
  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  // Bit positions within stage_en
  localparam int unsigned STAGE_F  = 0;
  localparam int unsigned STAGE_D  = 1;
  localparam int unsigned STAGE_E  = 2;
  localparam int unsigned STAGE_M  = 3;
  localparam int unsigned STAGE_W  = 4;
  localparam int unsigned STAGE_PC = 5;

  // StStepWait is only reachable when single-step support is compiled in
  typedef enum logic [3:0] {
    StIdle,
    StFetch,
    StDecode,
    StExecute,
    StMemory,
    StWrback,
    StPcUpd,
    StHalted,
    StStepWait
  } seq_state_e;

  // Instructions that touch data memory in the MEMORY stage
  function automatic logic needs_dmem(input logic [3:0] icode);
    logic r;
    case (icode)
      IRMMOVQ, IMRMOVQ, ICALL, IRET, IPUSHQ, IPOPQ: r = 1'b1;
      default:                                      r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/y86_wait_timer.sv
// Loadable down-counter measuring how long a memory request has been waiting.
// clr_i reloads Limit on state entry; expire_o flags the Limit-th waiting cycle.
// Limit = 0 never expires. armed_o is set once the request has been up a cycle.
module y86_wait_timer #(
  parameter int unsigned Limit = 15
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic armed_o,
  output logic expire_o
);

  localparam int unsigned CntW = (Limit > 0) ? $clog2(Limit + 1) : 1;
  localparam logic [CntW-1:0] LimitVal = CntW'(Limit);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            armed_q, armed_d;

  // Reload on clear, otherwise count down while waiting (saturating at zero)
  always_comb begin
    cnt_d   = cnt_q;
    armed_d = armed_q;
    if (clr_i) begin
      cnt_d   = LimitVal;
      armed_d = 1'b0;
    end else if (en_i) begin
      armed_d = 1'b1;
      if (cnt_q != '0) cnt_d = cnt_q - CntW'(1);
    end
  end

  // Counter state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
    end
  end

  assign armed_o  = armed_q;
  assign expire_o = en_i && (cnt_q == CntW'(1));

endmodule

// File: rtl/y86_stage_sequencer.sv
// Multi-cycle controller for the Y86 SEQ datapath.
// Walks F, D, E, M, W, PC one instruction at a time, handshakes with
// instruction/data memory and freezes once the status leaves AOK.
// Optional macro SEQ_SINGLE_STEP_EN adds a step input and a STEP_WAIT state.
// All outputs are registered from the next-state decode so they line up with
// the state register. A ready is only accepted once its request has been up
// for at least one cycle, so each handshake takes a minimum of two cycles.
module y86_stage_sequencer
  import y86_pkg::*;
#(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic             step,
`endif
  input  logic [3:0]       icode,
  input  logic [1:0]       fetch_stat,
  input  logic [1:0]       mem_stat,
  output logic             imem_req,
  input  logic             imem_ready,
  output logic             dmem_req,
  input  logic             dmem_ready,
  output logic [5:0]       stage_en,
  output logic             pc_we,
  output logic [1:0]       stat,
  output logic             halted,
  output logic             busy,
  output logic [CNT_W-1:0] insn_count
);

  seq_state_e       state_q, state_d;
  logic [1:0]       stat_q, stat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]       stage_en_q, stage_en_d;
  logic             imem_req_q, imem_req_d;
  logic             dmem_req_q, dmem_req_d;
  logic             pc_we_q, pc_we_d;
  logic             halted_q, halted_d;
  logic             busy_q, busy_d;

  logic waiting;
  logic armed;
  logic expire;
  logic ready_sel;
  logic accept;

  // A request is outstanding in FETCH and in MEMORY for memory-touching icodes
  always_comb begin
    waiting   = (state_q == StFetch) || ((state_q == StMemory) && needs_dmem(icode));
    ready_sel = (state_q == StFetch) ? imem_ready : dmem_ready;
    accept    = waiting && armed && ready_sel;
  end

  y86_wait_timer #(
    .Limit (MEM_TIMEOUT)
  ) u_wait_timer (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .clr_i    (state_d != state_q),
    .en_i     (waiting),
    .armed_o  (armed),
    .expire_o (expire)
  );

  // Next-state, status latch and retire counter; ready takes priority over timeout
  always_comb begin
    state_d = state_q;
    stat_d  = stat_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StFetch;
      end
      StFetch: begin
        if (accept) begin
          if (fetch_stat != STAT_AOK) begin
            stat_d  = fetch_stat;
            state_d = StHalted;
          end else begin
            state_d = StDecode;
          end
        end else if (expire) begin
          stat_d  = STAT_ADR;
          state_d = StHalted;
        end
      end
      StDecode:  state_d = StExecute;
      StExecute: state_d = StMemory;
      StMemory: begin
        if (!needs_dmem(icode)) begin
          state_d = StWrback;
        end else if (accept) begin
          if (mem_stat != STAT_AOK) begin
            stat_d  = mem_stat;
            state_d = StHalted;
          end else begin
            state_d = StWrback;
          end
        end else if (expire) begin
          stat_d  = STAT_ADR;
          state_d = StHalted;
        end
      end
      StWrback: state_d = StPcUpd;
`ifdef SEQ_SINGLE_STEP_EN
      StPcUpd:    state_d = StStepWait;
      StStepWait: begin
        if (step || start) state_d = StFetch;
      end
`else
      StPcUpd:    state_d = StFetch;
`endif
      StHalted: state_d = StHalted;
      default:  state_d = StIdle;
    endcase
    // Retire count moves on the same edge that raises pc_we
    if (state_d == StPcUpd) cnt_d = cnt_q + CNT_W'(1);
  end

  // Output decode of the upcoming state, registered below
  always_comb begin
    stage_en_d = '0;
    imem_req_d = 1'b0;
    dmem_req_d = 1'b0;
    pc_we_d    = 1'b0;
    halted_d   = (state_d == StHalted);
    busy_d     = (state_d != StIdle) && (state_d != StHalted);
    unique case (state_d)
      StFetch: begin
        stage_en_d[STAGE_F] = 1'b1;
        imem_req_d          = 1'b1;
      end
      StDecode:  stage_en_d[STAGE_D] = 1'b1;
      StExecute: stage_en_d[STAGE_E] = 1'b1;
      StMemory: begin
        stage_en_d[STAGE_M] = 1'b1;
        dmem_req_d          = needs_dmem(icode);
      end
      StWrback:  stage_en_d[STAGE_W] = 1'b1;
      StPcUpd: begin
        stage_en_d[STAGE_PC] = 1'b1;
        pc_we_d              = 1'b1;
      end
      default: ;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      stat_q     <= STAT_AOK;
      cnt_q      <= '0;
      stage_en_q <= '0;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      pc_we_q    <= 1'b0;
      halted_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      stat_q     <= stat_d;
      cnt_q      <= cnt_d;
      stage_en_q <= stage_en_d;
      imem_req_q <= imem_req_d;
      dmem_req_q <= dmem_req_d;
      pc_we_q    <= pc_we_d;
      halted_q   <= halted_d;
      busy_q     <= busy_d;
    end
  end

  assign stage_en   = stage_en_q;
  assign imem_req   = imem_req_q;
  assign dmem_req   = dmem_req_q;
  assign pc_we      = pc_we_q;
  assign stat       = stat_q;
  assign halted     = halted_q;
  assign busy       = busy_q;
  assign insn_count = cnt_q;

endmodule

// File: tb/tb_y86_stage_sequencer.sv
// Directed bench for y86_stage_sequencer (MEM_TIMEOUT = 4).
module tb_y86_stage_sequencer;
  import y86_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
  logic        step = 1'b0;
`endif
  logic [3:0]  icode = IOPQ;
  logic [1:0]  fetch_stat = STAT_AOK;
  logic [1:0]  mem_stat = STAT_AOK;
  logic        imem_req;
  logic        imem_ready = 1'b0;
  logic        dmem_req;
  logic        dmem_ready = 1'b0;
  logic [5:0]  stage_en;
  logic        pc_we;
  logic [1:0]  stat;
  logic        halted;
  logic        busy;
  logic [31:0] insn_count;

  always #5 clk = ~clk;

  y86_stage_sequencer #(
    .CNT_W       (32),
    .MEM_TIMEOUT (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
`ifdef SEQ_SINGLE_STEP_EN
    .step       (step),
`endif
    .icode      (icode),
    .fetch_stat (fetch_stat),
    .mem_stat   (mem_stat),
    .imem_req   (imem_req),
    .imem_ready (imem_ready),
    .dmem_req   (dmem_req),
    .dmem_ready (dmem_ready),
    .stage_en   (stage_en),
    .pc_we      (pc_we),
    .stat       (stat),
    .halted     (halted),
    .busy       (busy),
    .insn_count (insn_count)
  );

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n      = 1'b0;
    start      = 1'b0;
    icode      = IOPQ;
    fetch_stat = STAT_AOK;
    mem_stat   = STAT_AOK;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
    step       = 1'b1;
`endif
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic [5:0] exp1 [8];
  logic [5:0] exp2 [9];
  logic       exp2_dm [9];
  int         pc_cnt;
  int         req_cnt;
  int         bad;
  int         waited;

  initial begin
    exp1    = '{6'd1, 6'd1, 6'd2, 6'd4, 6'd8, 6'd16, 6'd32, 6'd1};
`ifdef SEQ_SINGLE_STEP_EN
    exp1[7] = 6'd0;
`endif
    exp2    = '{6'd1, 6'd1, 6'd2, 6'd4, 6'd8, 6'd8, 6'd8, 6'd16, 6'd32};
    exp2_dm = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    // Reset values
    apply_reset();
`ifdef SEQ_SINGLE_STEP_EN
    step = 1'b0;
`endif
    check_eq("rst_stage_en", stage_en, 6'd0);
    check_eq("rst_reqs", {imem_req, dmem_req, pc_we}, 3'b000);
    check_eq("rst_stat", stat, STAT_AOK);
    check_eq("rst_flags", {halted, busy}, 2'b00);
    check_eq("rst_count", insn_count, 32'd0);

    // OPq with both readies tied high: one-hot walk, single pc_we, no dmem_req
    icode      = IOPQ;
    imem_ready = 1'b1;
    dmem_ready = 1'b1;
    pulse_start();
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      check_eq($sformatf("opq_stage_en[%0d]", i), stage_en, exp1[i]);
      check_eq($sformatf("opq_pc_we[%0d]", i), pc_we, (i == 6));
      if (dmem_req) bad++;
    end
    check_eq("opq_dmem_req_cycles", bad, 0);
    check_eq("opq_insn_count", insn_count, 32'd1);

`ifdef SEQ_SINGLE_STEP_EN
    // Parked in STEP_WAIT until step
    check_eq("step_wait_busy", busy, 1'b1);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (imem_req || stage_en != 6'd0) bad++;
    end
    check_eq("step_wait_idle", bad, 0);
    step = 1'b1;
    tick();
    step = 1'b0;
    check_eq("step_fetch_req", {imem_req, stage_en}, {1'b1, 6'd1});
`endif

    // mrmovq with dmem_ready arriving on the third request cycle
    apply_reset();
    icode      = IMRMOVQ;
    imem_ready = 1'b1;
    pulse_start();
    for (int i = 0; i < 9; i++) begin
      if (i > 0) tick();
      check_eq($sformatf("mrm_stage_en[%0d]", i), stage_en, exp2[i]);
      check_eq($sformatf("mrm_dmem_req[%0d]", i), dmem_req, exp2_dm[i]);
      if (i == 6) dmem_ready = 1'b1;
    end
    check_eq("mrm_pc_we", pc_we, 1'b1);
    check_eq("mrm_insn_count", insn_count, 32'd1);
    check_eq("mrm_stat", stat, STAT_AOK);

    // Halt on the third fetch
    apply_reset();
    icode      = IOPQ;
    imem_ready = 1'b1;
    dmem_ready = 1'b1;
    pulse_start();
    pc_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (i > 0) tick();
      if (pc_we) pc_cnt++;
      if (pc_cnt == 2) fetch_stat = STAT_HLT;
    end
    check_eq("hlt_stat", stat, STAT_HLT);
    check_eq("hlt_flags", {halted, busy}, 2'b10);
    check_eq("hlt_pc_we_pulses", pc_cnt, 2);
    check_eq("hlt_insn_count", insn_count, 32'd2);
    start = 1'b1;
    bad   = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (!halted || stage_en != 6'd0 || pc_we || imem_req || stat != STAT_HLT) bad++;
    end
    start = 1'b0;
    check_eq("hlt_frozen_cycles", bad, 0);

    // pushq with no dmem_ready: timeout after 4 request cycles
    apply_reset();
    icode      = IPUSHQ;
    imem_ready = 1'b1;
    pulse_start();
    req_cnt = 0;
    pc_cnt  = 0;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) tick();
      if (dmem_req) req_cnt++;
      if (pc_we) pc_cnt++;
    end
    check_eq("dto_req_cycles", req_cnt, 4);
    check_eq("dto_pc_we", pc_cnt, 0);
    check_eq("dto_stat", stat, STAT_ADR);
    check_eq("dto_halted", halted, 1'b1);

    // Instruction fetch timeout
    apply_reset();
    pulse_start();
    req_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) tick();
      if (imem_req) req_cnt++;
    end
    check_eq("ito_req_cycles", req_cnt, 4);
    check_eq("ito_stat", stat, STAT_ADR);

    // Ready on the same cycle the timeout would fire: ready wins
    apply_reset();
    icode      = IMRMOVQ;
    imem_ready = 1'b1;
    pulse_start();
    req_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) tick();
      if (dmem_req) req_cnt++;
      if (i == 7) dmem_ready = 1'b1;
    end
    check_eq("race_req_cycles", req_cnt, 4);
    check_eq("race_stat_halted", {stat, halted}, {STAT_AOK, 1'b0});
    check_eq("race_insn_count", insn_count, 32'd1);

    // Reset while a data request is outstanding
    icode      = IRET;
    dmem_ready = 1'b0;
    waited     = 0;
    while (!dmem_req && waited < 12) begin
      tick();
      waited++;
    end
    check_eq("arst_pre_dmem_req", dmem_req, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_stage_en", stage_en, 6'd0);
    check_eq("arst_reqs", {imem_req, dmem_req, pc_we}, 3'b000);
    check_eq("arst_flags", {halted, busy, stat}, 4'b0000);
    check_eq("arst_count", insn_count, 32'd0);
    tick();
    rst_n      = 1'b1;
    dmem_ready = 1'b1;
    pulse_start();
    check_eq("arst_restart", {imem_req, stage_en}, {1'b1, 6'd1});
    waited = 0;
    while (!pc_we && waited < 12) begin
      tick();
      waited++;
    end
    check_eq("arst_latency", waited, 7);
    check_eq("arst_insn_count", insn_count, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
